// File: rtl/player_mover.sv
// Frame-rate sprite mover: synchronized buttons, clamped (or toroidal with
// PLAYER_WRAP_EN defined) position update, facing tracking and walk animation.
module player_mover #(
  parameter int unsigned START_R  = 300,
  parameter int unsigned START_C  = 300,
  parameter int unsigned STEP     = 2,
  parameter int unsigned MAX_R    = 464,
  parameter int unsigned MAX_C    = 624,
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] player_r,
  output logic [9:0] player_c,
  output logic [1:0] facing,
  output logic [1:0] anim_frame,
  output logic       moving
);

  // state  | meaning
  // S_IDLE | no net movement on the last frame tick, animation parked at 0
  // S_WALK | at least one axis had nonzero net movement on the last tick
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WALK = 1'b1;

  localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] MAX_R11 = 11'(MAX_R);
  localparam logic [10:0] MAX_C11 = 11'(MAX_C);

  localparam logic [1:0] FACE_UP    = 2'd0;
  localparam logic [1:0] FACE_DOWN  = 2'd1;
  localparam logic [1:0] FACE_LEFT  = 2'd2;
  localparam logic [1:0] FACE_RIGHT = 2'd3;

  logic [3:0]       btn_meta;
  logic [3:0]       btn_sync;
  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;

  logic v_inc, v_dec, h_inc, h_dec, any_move;
  logic [9:0] r_next, c_next;

  // Arithmetic is done at 11 bits so the intermediate sum never wraps.
  function automatic logic [9:0] inc_pos(input logic [9:0] pos, input logic [10:0] max_p);
    logic [10:0] sum;
    sum = {1'b0, pos} + STEP11;
`ifdef PLAYER_WRAP_EN
    if (sum > max_p) sum = sum - (max_p + 11'd1);
`else
    if (sum > max_p) sum = max_p;
`endif
    return sum[9:0];
  endfunction

  function automatic logic [9:0] dec_pos(input logic [9:0] pos, input logic [10:0] max_p);
    logic [10:0] p;
    p = {1'b0, pos};
    if (p < STEP11) begin
`ifdef PLAYER_WRAP_EN
      p = p + max_p + 11'd1 - STEP11;
`else
      p = 11'd0;
`endif
    end else begin
      p = p - STEP11;
    end
    return p[9:0];
  endfunction

  // btn_sync bit order: {up, down, left, right}
  always_comb begin
    v_inc    = btn_sync[2] & ~btn_sync[3];
    v_dec    = btn_sync[3] & ~btn_sync[2];
    h_inc    = btn_sync[0] & ~btn_sync[1];
    h_dec    = btn_sync[1] & ~btn_sync[0];
    any_move = v_inc | v_dec | h_inc | h_dec;

    r_next = player_r;
    if (v_inc)      r_next = inc_pos(player_r, MAX_R11);
    else if (v_dec) r_next = dec_pos(player_r, MAX_R11);

    c_next = player_c;
    if (h_inc)      c_next = inc_pos(player_c, MAX_C11);
    else if (h_dec) c_next = dec_pos(player_c, MAX_C11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta   <= '0;
      btn_sync   <= '0;
      player_r   <= 10'(START_R);
      player_c   <= 10'(START_C);
      facing     <= FACE_DOWN;
      anim_frame <= 2'd0;
      state      <= S_IDLE;
      div_cnt    <= '0;
    end else begin
      btn_meta <= {btn_up, btn_down, btn_left, btn_right};
      btn_sync <= btn_meta;
      if (frame_tick) begin
        player_r <= r_next;
        player_c <= c_next;
        // Horizontal wins over vertical; no net movement keeps the old facing.
        if (h_inc)      facing <= FACE_RIGHT;
        else if (h_dec) facing <= FACE_LEFT;
        else if (v_inc) facing <= FACE_DOWN;
        else if (v_dec) facing <= FACE_UP;

        if (!any_move) begin
          state      <= S_IDLE;
          div_cnt    <= '0;
          anim_frame <= 2'd0;
        end else begin
          state <= S_WALK;
          if (state == S_WALK) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt    <= '0;
              anim_frame <= anim_frame + 2'd1;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end
      end
    end
  end

  assign moving = (state == S_WALK);

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: a default instance plus an edge-start
// instance (row 1, column 623) share all stimulus to hit the wall boundaries.
module tb_player_mover;

  logic clk = 1'b0;
  logic rst, frame_tick, btn_up, btn_down, btn_left, btn_right;
  logic [9:0] pr_a, pc_a, pr_b, pc_b;
  logic [1:0] face_a, anim_a, face_b, anim_b;
  logic mov_a, mov_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  player_mover dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .player_r(pr_a), .player_c(pc_a), .facing(face_a), .anim_frame(anim_a), .moving(mov_a)
  );

  player_mover #(.START_R(1), .START_C(623)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .player_r(pr_b), .player_c(pc_b), .facing(face_b), .anim_frame(anim_b), .moving(mov_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse frame_tick for one clock; returns at the following negedge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    chk("rst_r",    16'(pr_a),   16'd300);
    chk("rst_c",    16'(pc_a),   16'd300);
    chk("rst_face", 16'(face_a), 16'd1);
    chk("rst_anim", 16'(anim_a), 16'd0);
    chk("rst_mov",  16'(mov_a),  16'd0);
    chk("rst_b_r",  16'(pr_b),   16'd1);

    // Walk right; the edge instance clamps at 624 but keeps walking.
    btn_right = 1'b1;
    wait_cyc(3);
    tick();
    chk("r1_c",    16'(pc_a),   16'd302);
    chk("r1_r",    16'(pr_a),   16'd300);
    chk("r1_face", 16'(face_a), 16'd3);
    chk("r1_mov",  16'(mov_a),  16'd1);
    chk("r1_b_c",  16'(pc_b),   16'd624);
    chk("r1_b_mov",16'(mov_b),  16'd1);
    tick();
    chk("r2_c",    16'(pc_a),   16'd304);
    chk("r2_b_c",  16'(pc_b),   16'd624);
    tick();
    chk("r3_c",    16'(pc_a),   16'd306);
    chk("r3_r",    16'(pr_a),   16'd300);
    for (int t = 4; t <= 8; t++) tick();
    chk("r8_anim", 16'(anim_a), 16'd0);
    tick();
    chk("r9_anim", 16'(anim_a), 16'd1);
    for (int t = 10; t <= 16; t++) tick();
    chk("r16_anim", 16'(anim_a), 16'd1);
    tick();
    chk("r17_anim",   16'(anim_a), 16'd2);
    chk("r17_c",      16'(pc_a),   16'd334);
    chk("r17_b_anim", 16'(anim_b), 16'd2);
    chk("r17_b_c",    16'(pc_b),   16'd624);

    // Release: back to idle, animation parked, facing held.
    btn_right = 1'b0;
    wait_cyc(3);
    tick();
    chk("rel_anim", 16'(anim_a), 16'd0);
    chk("rel_mov",  16'(mov_a),  16'd0);
    chk("rel_face", 16'(face_a), 16'd3);
    chk("rel_c",    16'(pc_a),   16'd334);

    // A press that ends before the tick has no effect.
    btn_left = 1'b1;
    wait_cyc(5);
    btn_left = 1'b0;
    wait_cyc(3);
    tick();
    chk("pulse_c",   16'(pc_a),  16'd334);
    chk("pulse_mov", 16'(mov_a), 16'd0);

    // Up: edge instance row 1 clamps to 0 and stays there.
    btn_up = 1'b1;
    wait_cyc(3);
    tick();
    chk("up1_r",    16'(pr_a),   16'd298);
    chk("up1_face", 16'(face_a), 16'd0);
    chk("up1_b_r",  16'(pr_b),   16'd0);
    tick();
    chk("up2_r",   16'(pr_a), 16'd296);
    chk("up2_b_r", 16'(pr_b), 16'd0);

    // Left+right cancel, down alone moves.
    btn_up = 1'b0; btn_left = 1'b1; btn_right = 1'b1; btn_down = 1'b1;
    wait_cyc(3);
    tick();
    chk("lrd_c",    16'(pc_a),   16'd334);
    chk("lrd_r",    16'(pr_a),   16'd298);
    chk("lrd_face", 16'(face_a), 16'd1);
    chk("lrd_mov",  16'(mov_a),  16'd1);
    chk("lrd_b_r",  16'(pr_b),   16'd2);

    // Reset coincident with frame_tick while walking.
    @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
    chk("rt_r",    16'(pr_a),   16'd300);
    chk("rt_c",    16'(pc_a),   16'd300);
    chk("rt_face", 16'(face_a), 16'd1);
    chk("rt_anim", 16'(anim_a), 16'd0);
    chk("rt_mov",  16'(mov_a),  16'd0);
    chk("rt_b_c",  16'(pc_b),   16'd623);

    btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
